serial_xs3_bcd_codec: RTL and testbench

//  Bidirectional bit-serial Excess-3 <-> BCD converter, successor to the single-digit Lab3 converter.

---
 rtl/serial_xs3_bcd_codec_pkg.sv | 18 +
 rtl/serial_xs3_bcd_codec_addsub.sv | 23 ++
 rtl/serial_xs3_bcd_codec.sv | 131 +++++++++++++
 tb/tb_serial_xs3_bcd_codec.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_xs3_bcd_codec_pkg.sv
// Shared constants and code-validity helpers for the serial Excess-3 <-> BCD codec.
package cv_pkg;

    localparam logic       MODE_XS3_TO_BCD = 1'b0;
    localparam logic       MODE_BCD_TO_XS3 = 1'b1;
    localparam logic [3:0] XS3_OFFSET      = 4'd3;
    localparam int         BITS_PER_DIGIT  = 4;

    // Excess-3 digits encode 0..9 as 3..12.
    function automatic logic xs3_valid(input logic [3:0] code);
        return (code >= 4'd3) && (code <= 4'd12);
    endfunction

    function automatic logic bcd_valid(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/serial_xs3_bcd_codec_addsub.sv
// One-bit serial add/subtract slice: adds (mode=1) or subtracts (mode=0) a constant bit k.
module serial_const_addsub
    import cv_pkg::*;
(
    input  logic x,
    input  logic k,
    input  logic c_in,
    input  logic mode,
    output logic z,
    output logic c_out
);

    always_comb begin
        z = x ^ k ^ c_in;
        // In subtract mode c_in/c_out carry a borrow rather than a carry.
        if (mode == MODE_BCD_TO_XS3) begin
            c_out = (x & k) | (x & c_in) | (k & c_in);
        end else begin
            c_out = (~x & k) | (~x & c_in) | (k & c_in);
        end
    end

endmodule

// File: rtl/serial_xs3_bcd_codec.sv
// Bit-serial Excess-3 <-> BCD converter with word framing; the per-digit
// code-validity check and sticky Err flag are built only when DIGIT_ERR_EN is defined.
module serial_xs3_bcd_codec
    import cv_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic Clk,
    input  logic Rst,
    input  logic X,
    input  logic Valid_in,
    input  logic Mode,
    output logic Z,
    output logic Valid_out,
    output logic Digit_done,
    output logic Word_done,
    output logic Err
);

    localparam int             DW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DW-1:0]  LAST_DIGIT = DW'(DIGITS - 1);
    localparam logic [1:0]     LAST_BIT   = 2'(BITS_PER_DIGIT - 1);

    logic [1:0]    bit_idx_q, bit_idx_d;
    logic [DW-1:0] digit_idx_q, digit_idx_d;
    logic          carry_q, carry_d;
    logic          mode_q, mode_d;

    logic          first_bit;
    logic          last_bit;
    logic          last_digit;
    logic          em;
    logic [3:0]    k_vec;
    logic          k_bit;
    logic          slice_z;
    logic          slice_c;

    assign first_bit  = (bit_idx_q == 2'd0) && (digit_idx_q == '0);
    assign last_bit   = (bit_idx_q == LAST_BIT);
    assign last_digit = (digit_idx_q == LAST_DIGIT);
    // The direction of a word is fixed by Mode on its very first bit.
    assign em         = first_bit ? Mode : mode_q;
    assign k_vec      = XS3_OFFSET;
    assign k_bit      = k_vec[bit_idx_q];

    serial_const_addsub u_slice (
        .x     (X),
        .k     (k_bit),
        .c_in  (carry_q),
        .mode  (em),
        .z     (slice_z),
        .c_out (slice_c)
    );

    assign Z          = Valid_in & slice_z;
    assign Valid_out  = Valid_in;
    assign Digit_done = Valid_in & last_bit;
    assign Word_done  = Valid_in & last_bit & last_digit;

    always_comb begin
        bit_idx_d   = bit_idx_q;
        digit_idx_d = digit_idx_q;
        carry_d     = carry_q;
        mode_d      = mode_q;
        if (Valid_in) begin
            bit_idx_d = bit_idx_q + 2'd1;
            // Each digit is converted mod 16: the carry out of bit 3 is dropped.
            carry_d   = last_bit ? 1'b0 : slice_c;
            if (first_bit) begin
                mode_d = Mode;
            end
            if (last_bit) begin
                digit_idx_d = last_digit ? '0 : digit_idx_q + DW'(1);
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            bit_idx_q   <= 2'd0;
            digit_idx_q <= '0;
            carry_q     <= 1'b0;
            mode_q      <= MODE_XS3_TO_BCD;
        end else begin
            bit_idx_q   <= bit_idx_d;
            digit_idx_q <= digit_idx_d;
            carry_q     <= carry_d;
            mode_q      <= mode_d;
        end
    end

`ifdef DIGIT_ERR_EN
    logic [2:0] shreg_q, shreg_d;
    logic       err_q, err_d;
    logic [3:0] code;
    logic       code_bad;

    // shreg fills from the top so that {X, shreg} is the digit MSB-first on bit 3.
    assign code     = {X, shreg_q};
    assign code_bad = (em == MODE_BCD_TO_XS3) ? !bcd_valid(code) : !xs3_valid(code);

    always_comb begin
        shreg_d = shreg_q;
        err_d   = err_q;
        if (Valid_in) begin
            shreg_d = {X, shreg_q[2:1]};
            if (first_bit) begin
                err_d = 1'b0;
            end
            if (last_bit && code_bad) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            shreg_q <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            err_q   <= err_d;
        end
    end

    assign Err = err_q;
`else
    assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_xs3_bcd_codec.sv
// Directed testbench for serial_xs3_bcd_codec (two-digit words); Err expectations follow DIGIT_ERR_EN.
module tb_serial_xs3_bcd_codec;

    localparam int DIGITS = 2;
`ifdef DIGIT_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    logic X = 1'b0;
    logic Valid_in = 1'b0;
    logic Mode = 1'b0;
    logic Z, Valid_out, Digit_done, Word_done, Err;

    int tests_run = 0;
    int tests_failed = 0;

    logic z_s, dd_s, wd_s, vo_s;

    serial_xs3_bcd_codec #(.DIGITS(DIGITS)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .X          (X),
        .Valid_in   (Valid_in),
        .Mode       (Mode),
        .Z          (Z),
        .Valid_out  (Valid_out),
        .Digit_done (Digit_done),
        .Word_done  (Word_done),
        .Err        (Err)
    );

    always #5 Clk = ~Clk;

    // Present one qualified bit, capture the Mealy outputs mid-cycle, return after the edge.
    task automatic drive_bit(input logic x, input logic m);
        @(negedge Clk);
        X = x;
        Mode = m;
        Valid_in = 1'b1;
        #1;
        z_s  = Z;
        dd_s = Digit_done;
        wd_s = Word_done;
        vo_s = Valid_out;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset;
        @(negedge Clk);
        Rst = 1'b1;
        Valid_in = 1'b0;
        X = 1'b0;
        Mode = 1'b0;
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic test_reset;
        Rst = 1'b1;
        Valid_in = 1'b0;
        repeat (2) @(negedge Clk);
        #1;
        tests_run++;
        if (Z !== 1'b0) begin tests_failed++; $display("FAIL reset_z: got %b expected 0", Z); end
        tests_run++;
        if (Digit_done !== 1'b0) begin tests_failed++; $display("FAIL reset_digit_done: got %b expected 0", Digit_done); end
        tests_run++;
        if (Word_done !== 1'b0) begin tests_failed++; $display("FAIL reset_word_done: got %b expected 0", Word_done); end
        tests_run++;
        if (Err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", Err); end
        tests_run++;
        if (Valid_out !== 1'b0) begin tests_failed++; $display("FAIL reset_valid_out: got %b expected 0", Valid_out); end
        @(negedge Clk);
        Rst = 1'b0;
        $display("[TB] test_reset done");
    endtask

    task automatic test_xs3_to_bcd;
        logic [3:0] xin, zexp;
        xin  = 4'b1100;
        zexp = 4'b1001;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_bit(xin[i], 1'b0);
            tests_run++;
            if (z_s !== zexp[i]) begin tests_failed++; $display("FAIL xs3_to_bcd_z b%0d: got %b expected %b", i, z_s, zexp[i]); end
            tests_run++;
            if (dd_s !== (i == 3)) begin tests_failed++; $display("FAIL xs3_to_bcd_digit_done b%0d: got %b expected %b", i, dd_s, (i == 3)); end
            tests_run++;
            if (wd_s !== 1'b0) begin tests_failed++; $display("FAIL xs3_to_bcd_word_done b%0d: got %b expected 0", i, wd_s); end
        end
        tests_run++;
        if (Err !== 1'b0) begin tests_failed++; $display("FAIL xs3_to_bcd_err: got %b expected 0", Err); end
        $display("[TB] test_xs3_to_bcd XS3 1100 -> BCD 1001");
    endtask

    task automatic test_bcd_to_xs3;
        logic [3:0] xin, zexp;
        xin  = 4'b0111;
        zexp = 4'b1010;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_bit(xin[i], 1'b1);
            tests_run++;
            if (z_s !== zexp[i]) begin tests_failed++; $display("FAIL bcd_to_xs3_z b%0d: got %b expected %b", i, z_s, zexp[i]); end
            tests_run++;
            if (dd_s !== (i == 3)) begin tests_failed++; $display("FAIL bcd_to_xs3_digit_done b%0d: got %b expected %b", i, dd_s, (i == 3)); end
        end
        tests_run++;
        if (Err !== 1'b0) begin tests_failed++; $display("FAIL bcd_to_xs3_err: got %b expected 0", Err); end
        $display("[TB] test_bcd_to_xs3 BCD 0111 -> XS3 1010");
    endtask

    task automatic test_digit_err;
        logic [3:0] xs [6];
        logic [3:0] zs [6];
        logic       ms [6];
        logic       err_mid [6];
        logic       err_end [6];
        logic       exp_err;
        xs = '{4'b0001, 4'b0011, 4'b0100, 4'b1101, 4'b1010, 4'b0101};
        zs = '{4'b1110, 4'b0000, 4'b0001, 4'b1010, 4'b1101, 4'b1000};
        ms = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        err_mid = '{1'b0, ERR_EN, 1'b0, 1'b0, 1'b0, ERR_EN};
        err_end = '{ERR_EN, ERR_EN, 1'b0, ERR_EN, ERR_EN, ERR_EN};
        do_reset();
        for (int d = 0; d < 6; d++) begin
            for (int i = 0; i < 4; i++) begin
                drive_bit(xs[d][i], ms[d]);
                exp_err = (i == 3) ? err_end[d] : err_mid[d];
                tests_run++;
                if (z_s !== zs[d][i]) begin tests_failed++; $display("FAIL digit_err_z d%0d b%0d: got %b expected %b", d, i, z_s, zs[d][i]); end
                tests_run++;
                if (Err !== exp_err) begin tests_failed++; $display("FAIL digit_err_err d%0d b%0d: got %b expected %b", d, i, Err, exp_err); end
                tests_run++;
                if (wd_s !== ((d % 2 == 1) && (i == 3))) begin
                    tests_failed++;
                    $display("FAIL digit_err_word_done d%0d b%0d: got %b expected %b", d, i, wd_s, ((d % 2 == 1) && (i == 3)));
                end
            end
            $display("[TB] test_digit_err digit %0d in=%b out=%b err=%b", d, xs[d], zs[d], Err);
        end
    endtask

    task automatic test_gaps_word;
        logic [3:0] xs [2];
        logic [3:0] zs [2];
        xs = '{4'b0011, 4'b1011};
        zs = '{4'b0000, 4'b1000};
        do_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                drive_bit(xs[d][i], 1'b0);
                tests_run++;
                if (z_s !== zs[d][i]) begin tests_failed++; $display("FAIL gaps_z d%0d b%0d: got %b expected %b", d, i, z_s, zs[d][i]); end
                tests_run++;
                if (vo_s !== 1'b1) begin tests_failed++; $display("FAIL gaps_valid_out d%0d b%0d: got %b expected 1", d, i, vo_s); end
                tests_run++;
                if (dd_s !== (i == 3)) begin tests_failed++; $display("FAIL gaps_digit_done d%0d b%0d: got %b expected %b", d, i, dd_s, (i == 3)); end
                tests_run++;
                if (wd_s !== ((d == 1) && (i == 3))) begin
                    tests_failed++;
                    $display("FAIL gaps_word_done d%0d b%0d: got %b expected %b", d, i, wd_s, ((d == 1) && (i == 3)));
                end
                // Idle cycles with a toggled X must neither emit nor advance.
                for (int g = 0; g < 1 + (i % 2); g++) begin
                    @(negedge Clk);
                    Valid_in = 1'b0;
                    X = ~X;
                    Mode = 1'b1;
                    #1;
                    tests_run++;
                    if ({Z, Valid_out, Digit_done, Word_done} !== 4'b0000) begin
                        tests_failed++;
                        $display("FAIL gaps_idle d%0d b%0d: got %b expected 0000", d, i, {Z, Valid_out, Digit_done, Word_done});
                    end
                end
            end
            $display("[TB] test_gaps_word digit %0d XS3 %b -> BCD %b", d, xs[d], zs[d]);
        end
    endtask

    task automatic test_mode_latch;
        logic [3:0] xs [4];
        logic [3:0] zs [4];
        logic       m;
        xs = '{4'b1100, 4'b0101, 4'b0000, 4'b1001};
        zs = '{4'b1001, 4'b0010, 4'b0011, 4'b1100};
        do_reset();
        for (int d = 0; d < 4; d++) begin
            for (int i = 0; i < 4; i++) begin
                case (d)
                    0:       m = (i >= 2);
                    3:       m = 1'b0;
                    default: m = 1'b1;
                endcase
                drive_bit(xs[d][i], m);
                tests_run++;
                if (z_s !== zs[d][i]) begin tests_failed++; $display("FAIL mode_latch_z d%0d b%0d: got %b expected %b", d, i, z_s, zs[d][i]); end
            end
            tests_run++;
            if (Err !== 1'b0) begin tests_failed++; $display("FAIL mode_latch_err d%0d: got %b expected 0", d, Err); end
            $display("[TB] test_mode_latch digit %0d in=%b out=%b", d, xs[d], zs[d]);
        end
    endtask

    task automatic test_async_reset;
        logic [3:0] xs [4];
        logic [3:0] zs [4];
        xs = '{4'b0001, 4'b0101, 4'b0101, 4'b1100};
        zs = '{4'b1110, 4'b0010, 4'b0010, 4'b1001};
        do_reset();
        for (int i = 0; i < 4; i++) drive_bit(xs[0][i], 1'b0);
        for (int i = 0; i < 2; i++) drive_bit(xs[1][i], 1'b0);
        tests_run++;
        if (Err !== ERR_EN) begin tests_failed++; $display("FAIL async_reset_err_before: got %b expected %b", Err, ERR_EN); end
        @(negedge Clk);
        Valid_in = 1'b0;
        #2;
        Rst = 1'b1;
        #1;
        tests_run++;
        if (Err !== 1'b0) begin tests_failed++; $display("FAIL async_reset_err_cleared: got %b expected 0", Err); end
        #1;
        Rst = 1'b0;
        for (int d = 2; d < 4; d++) begin
            for (int i = 0; i < 4; i++) begin
                drive_bit(xs[d][i], 1'b0);
                tests_run++;
                if (z_s !== zs[d][i]) begin tests_failed++; $display("FAIL async_reset_z d%0d b%0d: got %b expected %b", d, i, z_s, zs[d][i]); end
                tests_run++;
                if (dd_s !== (i == 3)) begin tests_failed++; $display("FAIL async_reset_digit_done d%0d b%0d: got %b expected %b", d, i, dd_s, (i == 3)); end
                tests_run++;
                if (wd_s !== ((d == 3) && (i == 3))) begin
                    tests_failed++;
                    $display("FAIL async_reset_word_done d%0d b%0d: got %b expected %b", d, i, wd_s, ((d == 3) && (i == 3)));
                end
            end
            $display("[TB] test_async_reset digit %0d XS3 %b -> BCD %b", d, xs[d], zs[d]);
        end
        tests_run++;
        if (Err !== 1'b0) begin tests_failed++; $display("FAIL async_reset_err_after: got %b expected 0", Err); end
    endtask

    initial begin
        test_reset();
        test_xs3_to_bcd();
        test_bcd_to_xs3();
        test_digit_err();
        test_gaps_word();
        test_mode_latch();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
